task_ctrl_param: RTL and testbench

- Parametrised task control block for the FPGA-side hardware scheduler. One instance per task.
- Decodes the shared 16-bit operation bus and keeps the task's state, priority and remaining execution hits.
- Adds priority aging, a running state, wait timeouts and auto-termination on hit exhaustion.
- Presents a registered {id, priority} word to the downstream sorter.

---
 rtl/task_ctrl_param.sv | 162 ++++++++++++++++
 tb/tb_task_ctrl_param.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module : task_ctrl_param
// Per-task scheduler control: op-bus decode, state, priority aging, wait timer.
// Rev    : 1.0  initial release
// ============================================================================
module task_ctrl_param #(
    parameter logic [3:0]       TASK_ID      = 4'd6,
    parameter int               PRIO_W       = 4,
    parameter int               HIT_W        = 8,
    parameter int               AGING_PERIOD = 10000,
    parameter int               WAIT_UNIT    = 256,
    parameter logic [HIT_W-1:0] INIT_HIT     = HIT_W'(8'h80)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [15:0]         in_op,
    output logic [3+PRIO_W:0]   out_sorter,
    output logic [2:0]          out_state,
    output logic                out_done
);

    localparam int AGE_W  = $clog2(AGING_PERIOD);
    localparam int WAIT_W = $clog2(15 * WAIT_UNIT + 1);

    localparam logic [AGE_W-1:0]  C_AGE_LAST  = AGE_W'(AGING_PERIOD - 1);
    localparam logic [WAIT_W-1:0] C_WAIT_UNIT = WAIT_W'(WAIT_UNIT);

    localparam logic [3:0] OP_READY   = 4'h1;
    localparam logic [3:0] OP_SUSPEND = 4'h2;
    localparam logic [3:0] OP_WAIT    = 4'h3;
    localparam logic [3:0] OP_KILL    = 4'h4;
    localparam logic [3:0] OP_SETPRIO = 4'h5;
    localparam logic [3:0] OP_SETHIT  = 4'h6;
    localparam logic [3:0] OP_EXEC    = 4'h7;
    localparam logic [3:0] OP_KILL2   = 4'hC;
    localparam logic [3:0] OP_FINISH  = 4'hF;

    typedef enum logic [2:0] {
        ST_READY = 3'd0,
        ST_SUSP  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_TERM  = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PRIO_W-1:0]   prio_q, prio_d;
    logic [HIT_W-1:0]    hits_q, hits_d;
    logic [AGE_W-1:0]    age_q, age_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [3+PRIO_W:0]   sorter_q;
    logic                done_q;
    logic                term_seen_q;

    logic [3:0] id_w, opc_w, opnd_w;
    logic       bcast_ok_w, hit_w;
    logic       unused_bits_w;

    assign id_w          = in_op[11:8];
    assign opc_w         = in_op[7:4];
    assign opnd_w        = in_op[3:0];
    assign unused_bits_w = ^in_op[15:12];

    assign bcast_ok_w = (opc_w == OP_READY) || (opc_w == OP_SUSPEND) ||
                        (opc_w == OP_KILL)  || (opc_w == OP_KILL2);
    assign hit_w      = (id_w == TASK_ID) || ((id_w == 4'hF) && bcast_ok_w);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        hits_d  = hits_q;
        age_d   = age_q;
        wait_d  = wait_q;

        // Background aging and wait expiry first, so explicit ops below win.
        if (state_q == ST_READY) begin
            if (age_q == C_AGE_LAST) begin
                age_d = '0;
                if (prio_q != '1) prio_d = prio_q + PRIO_W'(1);
            end else begin
                age_d = age_q + AGE_W'(1);
            end
        end
        if (state_q == ST_WAIT) begin
            wait_d = wait_q - WAIT_W'(1);
            if (wait_q == WAIT_W'(1)) state_d = ST_READY;
        end

        if (hit_w && (state_q != ST_TERM)) begin
            case (opc_w)
                OP_READY: begin
                    if ((state_q == ST_SUSP) || (state_q == ST_WAIT)) begin
                        state_d = ST_READY;
                        wait_d  = '0;
                    end
                end
                OP_SUSPEND: begin
                    if ((state_q == ST_READY) || (state_q == ST_RUN) || (state_q == ST_WAIT))
                        state_d = ST_SUSP;
                end
                OP_WAIT: begin
                    if ((opnd_w != 4'd0) && ((state_q == ST_READY) || (state_q == ST_RUN))) begin
                        state_d = ST_WAIT;
                        wait_d  = WAIT_W'(opnd_w) * C_WAIT_UNIT;
                    end
                end
                OP_KILL, OP_KILL2: state_d = ST_TERM;
                OP_SETPRIO:        prio_d  = PRIO_W'(opnd_w);
                OP_SETHIT:         hits_d  = HIT_W'(opnd_w);
                OP_EXEC: begin
                    if ((state_q == ST_READY) && (hits_q != '0)) begin
                        state_d = ST_RUN;
                        hits_d  = hits_q - HIT_W'(1);
                        age_d   = '0;
                        prio_d  = '0;
                    end
                end
                OP_FINISH: begin
                    if (state_q == ST_RUN) begin
                        if (hits_q == '0) begin
                            state_d = ST_TERM;
                        end else begin
                            state_d = ST_READY;
                            age_d   = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_READY;
            prio_q      <= '0;
            hits_q      <= INIT_HIT;
            age_q       <= '0;
            wait_q      <= '0;
            sorter_q    <= '0;
            done_q      <= 1'b0;
            term_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            hits_q      <= hits_d;
            age_q       <= age_d;
            wait_q      <= wait_d;
            // Sorter word and done pulse lag the registered state by one edge.
            sorter_q    <= (state_q == ST_READY) ? {TASK_ID, prio_q} : '0;
            done_q      <= (state_q == ST_TERM) && !term_seen_q;
            term_seen_q <= (state_q == ST_TERM);
        end
    end

    assign out_sorter = sorter_q;
    assign out_state  = state_q;
    assign out_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_task_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module : tb_task_ctrl_param
// Scoreboard bench for task_ctrl_param (AGING_PERIOD=4, WAIT_UNIT=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_task_ctrl_param;

    localparam int AP = 4;
    localparam int WU = 8;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] in_op;
    logic [7:0]  out_sorter;
    logic [2:0]  out_state;
    logic        out_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] exp_q[$];

    // Reference model state
    logic [2:0] m_state = 3'd0;
    logic [3:0] m_prio  = 4'd0;
    logic [7:0] m_hit   = 8'h80;
    int         m_age   = 0;
    int         m_wait  = 0;
    logic       m_seen  = 1'b0;

    task_ctrl_param #(
        .TASK_ID      (4'd6),
        .PRIO_W       (4),
        .HIT_W        (8),
        .AGING_PERIOD (AP),
        .WAIT_UNIT    (WU),
        .INIT_HIT     (8'h80)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_op      (in_op),
        .out_sorter (out_sorter),
        .out_state  (out_state),
        .out_done   (out_done)
    );

    always #5 CLK = ~CLK;

    task automatic model_step(input logic [15:0] op, input logic rst_n);
        logic [3:0] id, opc, opn;
        logic       hit;
        logic [2:0] ns;
        logic [3:0] np;
        logic [7:0] nh;
        int         na, nw;
        logic [7:0] srt;
        logic       dn;
        id = op[11:8]; opc = op[7:4]; opn = op[3:0];
        if (!rst_n) begin
            m_state = 3'd0; m_prio = 4'd0; m_hit = 8'h80;
            m_age = 0; m_wait = 0; m_seen = 1'b0;
            exp_q.push_back(12'h000);
        end else begin
            srt = (m_state == 3'd0) ? {4'h6, m_prio} : 8'h00;
            dn  = (m_state == 3'd3) && !m_seen;
            ns = m_state; np = m_prio; nh = m_hit; na = m_age; nw = m_wait;
            if (m_state == 3'd0) begin
                na = m_age + 1;
                if (na == AP) begin
                    na = 0;
                    np = (m_prio == 4'hF) ? 4'hF : m_prio + 4'd1;
                end
            end
            if (m_state == 3'd2) begin
                nw = m_wait - 1;
                if (nw == 0) ns = 3'd0;
            end
            hit = (id == 4'h6) ||
                  (id == 4'hF && (opc == 4'h1 || opc == 4'h2 || opc == 4'h4 || opc == 4'hC));
            if (hit && m_state != 3'd3) begin
                if (opc == 4'h1 && (m_state == 3'd1 || m_state == 3'd2)) begin
                    ns = 3'd0; nw = 0;
                end else if (opc == 4'h2 && (m_state == 3'd0 || m_state == 3'd4 || m_state == 3'd2)) begin
                    ns = 3'd1;
                end else if (opc == 4'h3 && opn != 0 && (m_state == 3'd0 || m_state == 3'd4)) begin
                    ns = 3'd2; nw = int'(opn) * WU;
                end else if (opc == 4'h4 || opc == 4'hC) begin
                    ns = 3'd3;
                end else if (opc == 4'h5) begin
                    np = opn;
                end else if (opc == 4'h6) begin
                    nh = {4'h0, opn};
                end else if (opc == 4'h7 && m_state == 3'd0 && m_hit != 0) begin
                    ns = 3'd4; nh = m_hit - 8'd1; na = 0; np = 4'd0;
                end else if (opc == 4'hF && m_state == 3'd4) begin
                    if (m_hit == 0) ns = 3'd3;
                    else begin ns = 3'd0; na = 0; end
                end
            end
            m_seen = (m_state == 3'd3);
            m_state = ns; m_prio = np; m_hit = nh; m_age = na; m_wait = nw;
            exp_q.push_back({ns, srt, dn});
        end
    endtask

    task automatic drive(input logic [15:0] op, input logic rst_n);
        in_op = op;
        RST_N = rst_n;
        model_step(op, rst_n);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        for (int i = 0; i < 5; i++) begin
            drive(16'h0000, (i >= 2));
            e = exp_q.pop_front();
            n_checks++;
            if ({out_state, out_sorter, out_done} !== e)
                $display("FAIL reset[%0d]: {state,sorter,done} got %h, expected %h", i, {out_state, out_sorter, out_done}, e);
            else n_pass++;
        end
        n_checks++;
        if (out_state !== 3'd0 || out_sorter !== 8'h60 || out_done !== 1'b0)
            $display("FAIL reset_idle: state/sorter/done got %0d/%h/%b, expected 0/60/0", out_state, out_sorter, out_done);
        else n_pass++;
    endtask

    task automatic test_dispatch();
        logic [15:0] ops[6];
        logic [11:0] e;
        ops = '{16'h0652, 16'h0670, 16'h0000, 16'h06F0, 16'h0000, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if ({out_state, out_sorter, out_done} !== e)
                $display("FAIL dispatch[%0d]: {state,sorter,done} got %h, expected %h", i, {out_state, out_sorter, out_done}, e);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (out_state !== 3'd4 || out_sorter !== 8'h62)
                    $display("FAIL dispatch_run: state/sorter got %0d/%h, expected 4/62", out_state, out_sorter);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if (out_sorter !== 8'h00)
                    $display("FAIL dispatch_sorter_off: sorter got %h, expected 00", out_sorter);
                else n_pass++;
            end
            if (i == 5) begin
                n_checks++;
                if (out_state !== 3'd0 || out_sorter !== 8'h60)
                    $display("FAIL finish_ready: state/sorter got %0d/%h, expected 0/60", out_state, out_sorter);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hits_kill();
        logic [16:0] ops[15];
        logic [11:0] e;
        ops = '{17'h1_0660, 17'h1_0670, 17'h1_06C0, 17'h1_0000, 17'h1_0000,
                17'h1_0610, 17'h0_0000, 17'h1_0661, 17'h1_0670, 17'h1_06F0,
                17'h1_0000, 17'h0_0000, 17'h1_0662, 17'h1_0670, 17'h1_06F0};
        for (int i = 0; i < 15; i++) begin
            drive(ops[i][15:0], ops[i][16]);
            e = exp_q.pop_front();
            n_checks++;
            if ({out_state, out_sorter, out_done} !== e)
                $display("FAIL hits_kill[%0d]: {state,sorter,done} got %h, expected %h", i, {out_state, out_sorter, out_done}, e);
            else n_pass++;
            case (i)
                1, 14: begin
                    n_checks++;
                    if (out_state !== 3'd0)
                        $display("FAIL exec_gate[%0d]: state got %0d, expected 0", i, out_state);
                    else n_pass++;
                end
                2, 5, 9: begin
                    n_checks++;
                    if (out_state !== 3'd3)
                        $display("FAIL terminated[%0d]: state got %0d, expected 3", i, out_state);
                    else n_pass++;
                end
                3, 10: begin
                    n_checks++;
                    if (out_done !== 1'b1)
                        $display("FAIL done_pulse[%0d]: done got %b, expected 1", i, out_done);
                    else n_pass++;
                end
                4: begin
                    n_checks++;
                    if (out_done !== 1'b0)
                        $display("FAIL done_width: done got %b, expected 0", out_done);
                    else n_pass++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_aging();
        logic [11:0] e;
        drive(16'h0000, 1'b0);
        e = exp_q.pop_front();
        for (int i = 0; i < 64; i++) begin
            drive(16'h0000, 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if ({out_state, out_sorter, out_done} !== e)
                $display("FAIL aging[%0d]: {state,sorter,done} got %h, expected %h", i, {out_state, out_sorter, out_done}, e);
            else n_pass++;
            if (i == 3 || i == 4) begin
                n_checks++;
                if (out_sorter !== ((i == 3) ? 8'h60 : 8'h61))
                    $display("FAIL aging_step[%0d]: sorter got %h, expected %h", i, out_sorter, (i == 3) ? 8'h60 : 8'h61);
                else n_pass++;
            end
        end
        n_checks++;
        if (out_sorter !== 8'h6F)
            $display("FAIL aging_saturate: sorter got %h, expected 6f", out_sorter);
        else n_pass++;
    endtask

    task automatic test_wait();
        logic [11:0] e;
        int          n_in_wait;
        n_in_wait = 0;
        for (int i = 0; i < 21; i++) begin
            drive((i == 0) ? 16'h0632 : 16'h0000, 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if ({out_state, out_sorter, out_done} !== e)
                $display("FAIL wait[%0d]: {state,sorter,done} got %h, expected %h", i, {out_state, out_sorter, out_done}, e);
            else n_pass++;
            if (out_state == 3'd2) n_in_wait++;
        end
        n_checks++;
        if (n_in_wait != 16 || out_state !== 3'd0)
            $display("FAIL wait_length: cycles in WAIT got %0d (final state %0d), expected 16 (0)", n_in_wait, out_state);
        else n_pass++;
        for (int i = 0; i < 7; i++) begin
            drive((i == 0) ? 16'h0630 : (i == 1) ? 16'h0632 : (i == 6) ? 16'h0610 : 16'h0000, 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if ({out_state, out_sorter, out_done} !== e)
                $display("FAIL wait_abort[%0d]: {state,sorter,done} got %h, expected %h", i, {out_state, out_sorter, out_done}, e);
            else n_pass++;
            if (i == 0 || i == 6 || i == 5) begin
                n_checks++;
                if (out_state !== ((i == 5) ? 3'd2 : 3'd0))
                    $display("FAIL wait_abort_state[%0d]: state got %0d, expected %0d", i, out_state, (i == 5) ? 2 : 0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_broadcast();
        logic [16:0] ops[12];
        logic [11:0] e;
        ops = '{17'h0_0000, 17'h1_0F20, 17'h1_0F50, 17'h1_0710, 17'h1_0F10, 17'h1_0720,
                17'h1_0000, 17'h1_0632, 17'h1_0000, 17'h1_0000, 17'h0_0610, 17'h1_0000};
        for (int i = 0; i < 12; i++) begin
            drive(ops[i][15:0], ops[i][16]);
            e = exp_q.pop_front();
            n_checks++;
            if ({out_state, out_sorter, out_done} !== e)
                $display("FAIL broadcast[%0d]: {state,sorter,done} got %h, expected %h", i, {out_state, out_sorter, out_done}, e);
            else n_pass++;
            case (i)
                1, 3: begin
                    n_checks++;
                    if (out_state !== 3'd1)
                        $display("FAIL bcast_suspend[%0d]: state got %0d, expected 1", i, out_state);
                    else n_pass++;
                end
                6, 11: begin
                    n_checks++;
                    if (out_state !== 3'd0 || out_sorter !== 8'h60)
                        $display("FAIL bcast_ready[%0d]: state/sorter got %0d/%h, expected 0/60", i, out_state, out_sorter);
                    else n_pass++;
                end
                10: begin
                    n_checks++;
                    if (out_state !== 3'd0 || out_sorter !== 8'h00)
                        $display("FAIL reset_mid_wait: state/sorter got %0d/%h, expected 0/00", out_state, out_sorter);
                    else n_pass++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        logic [3:0]  id, opc, opn;
        logic        rst_n;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       id = 4'hF;
                1:       id = 4'h7;
                default: id = 4'h6;
            endcase
            opc = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if ((opc == 4'h4 || opc == 4'hC) && $urandom_range(0, 3) != 0) opc = 4'h7;
            opn = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 40) != 0);
            drive({4'($urandom_range(0, 15)), id, opc, opn}, rst_n);
            e = exp_q.pop_front();
            n_checks++;
            if ({out_state, out_sorter, out_done} !== e)
                $display("FAIL random[%0d]: {state,sorter,done} got %h, expected %h", i, {out_state, out_sorter, out_done}, e);
            else n_pass++;
        end
    endtask

    initial begin
        in_op = 16'h0000;
        RST_N = 1'b0;
        test_reset();
        test_dispatch();
        test_hits_kill();
        test_aging();
        test_wait();
        test_broadcast();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
